// File: rtl/bin_a_bcd.sv
// bin_a_bcd: sequential binary-to-BCD converter (shift-add-3 / double dabble).
// Converts a BIN_W-bit unsigned value to four packed BCD digits, one shift per
// clock. Inputs above MAX_VAL saturate to MAX_VAL and flag overflow. The last
// result is held stable between conversions for a flicker-free display.
//
// Ports:
//   clk      system clock
//   rst      asynchronous reset, active-high
//   start    conversion request, sampled only in IDLE
//   bin      unsigned binary value, captured on the accepted start edge
//   bcd      packed BCD result {thousands, hundreds, tens, units}, held until next completion
//   busy     high while a conversion is in progress
//   done     single-cycle pulse when bcd is updated
//   overflow last converted input exceeded MAX_VAL, updated together with bcd
module bin_a_bcd #(
    parameter int unsigned BIN_W   = 14,
    parameter int unsigned MAX_VAL = 9999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic [15:0]      bcd,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned BCD_W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [BIN_W-1:0]   bin_work, bin_work_n;
    logic [BCD_W-1:0]   bcd_work, bcd_work_n;
    logic               ovf, ovf_n;
    logic [BCD_W-1:0]   bcd_n;
    logic               busy_n, done_n, overflow_n;
    logic [BCD_W-1:0]   corr;
    logic [BCD_W-1:0]   shifted_bcd;

    // Add 3 to a digit that would reach 10 or more after the next doubling.
    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    // All four digits corrected in parallel, then shifted left with the next binary bit.
    always_comb begin
        corr = '0;
        for (int i = 0; i < 4; i++) begin
            corr[i*4 +: 4] = add3(bcd_work[i*4 +: 4]);
        end
        shifted_bcd = {corr[BCD_W-2:0], bin_work[BIN_W-1]};
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bin_work <= '0;
            bcd_work <= '0;
            ovf      <= 1'b0;
            bcd      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bin_work <= bin_work_n;
            bcd_work <= bcd_work_n;
            ovf      <= ovf_n;
            bcd      <= bcd_n;
            busy     <= busy_n;
            done     <= done_n;
            overflow <= overflow_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        bin_work_n = bin_work;
        bcd_work_n = bcd_work;
        ovf_n      = ovf;
        bcd_n      = bcd;
        busy_n     = busy;
        done_n     = 1'b0;
        overflow_n = overflow;

        case (state)
            IDLE: begin
                if (start) begin
                    if (bin > BIN_W'(MAX_VAL)) begin
                        bin_work_n = BIN_W'(MAX_VAL);
                        ovf_n      = 1'b1;
                    end else begin
                        bin_work_n = bin;
                        ovf_n      = 1'b0;
                    end
                    bcd_work_n = '0;
                    cnt_n      = '0;
                    busy_n     = 1'b1;
                    state_n    = SHIFT;
                end
            end
            SHIFT: begin
                bcd_work_n = shifted_bcd;
                bin_work_n = {bin_work[BIN_W-2:0], 1'b0};
                cnt_n      = cnt + CNT_W'(1);
                // Last bit shifted in: publish the result.
                if (cnt == CNT_W'(BIN_W - 1)) begin
                    bcd_n      = shifted_bcd;
                    overflow_n = ovf;
                    done_n     = 1'b1;
                    busy_n     = 1'b0;
                    state_n    = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bin_a_bcd.sv
// Directed self-checking bench for bin_a_bcd.
module tb_bin_a_bcd;

    logic        clk;
    logic        rst;
    logic        start;
    logic [13:0] bin;
    logic [15:0] bcd;
    logic        busy;
    logic        done;
    logic        overflow;

    int tests_run;
    int tests_failed;

    bin_a_bcd #(.BIN_W(14), .MAX_VAL(9999)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin      (bin),
        .bcd      (bcd),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs and sampling happen here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until done is seen; ok=0 on timeout.
    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Issue a single-cycle start pulse with the given value.
    task automatic pulse_start(input logic [13:0] v);
        bin   = v;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        int done_seen;
        done_seen = 0;
        rst = 1'b1;
        start = 1'b0;
        bin = '0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) done_seen++;
        end
        tests_run++;
        if (bcd !== 16'h0000 || busy !== 1'b0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: bcd=%h busy=%b ovf=%b, required bcd=0000 busy=0 ovf=0", bcd, busy, overflow);
        end
        tests_run++;
        if (done_seen != 0) begin
            tests_failed++;
            $display("FAIL reset_no_done: done seen %0d times, required 0", done_seen);
        end
    endtask

    task automatic test_latency();
        int bad;
        bad = 0;
        pulse_start(14'd1234);
        // Observed after edges k..k+13: busy high, done low.
        for (int i = 0; i < 14; i++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            tick();
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL latency_busy: %0d bad cycles before edge k+14, required 0", bad);
        end
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0 || bcd !== 16'h1234 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL latency_done: done=%b busy=%b bcd=%h ovf=%b, required 1 0 1234 0", done, busy, bcd, overflow);
        end
        tick();
        tests_run++;
        if (done !== 1'b0 || bcd !== 16'h1234) begin
            tests_failed++;
            $display("FAIL done_pulse: done=%b bcd=%h, required 0 1234", done, bcd);
        end
    endtask

    task automatic test_boundaries();
        logic [13:0] vin [4];
        logic [15:0] vexp [4];
        bit ok;
        vin[0] = 14'd0;    vexp[0] = 16'h0000;
        vin[1] = 14'd9;    vexp[1] = 16'h0009;
        vin[2] = 14'd10;   vexp[2] = 16'h0010;
        vin[3] = 14'd9999; vexp[3] = 16'h9999;
        for (int i = 0; i < 4; i++) begin
            pulse_start(vin[i]);
            wait_done(ok);
            tests_run++;
            if (!ok || bcd !== vexp[i] || overflow !== 1'b0) begin
                tests_failed++;
                $display("FAIL boundary_%0d: ok=%b bcd=%h ovf=%b, required bcd=%h ovf=0", vin[i], ok, bcd, overflow, vexp[i]);
            end
            tick();
        end
    endtask

    task automatic test_overflow();
        logic [13:0] vin [3];
        logic [15:0] vexp [3];
        logic        vovf [3];
        bit ok;
        vin[0] = 14'd12000; vexp[0] = 16'h9999; vovf[0] = 1'b1;
        vin[1] = 14'd16383; vexp[1] = 16'h9999; vovf[1] = 1'b1;
        vin[2] = 14'd42;    vexp[2] = 16'h0042; vovf[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pulse_start(vin[i]);
            wait_done(ok);
            tests_run++;
            if (!ok || bcd !== vexp[i] || overflow !== vovf[i]) begin
                tests_failed++;
                $display("FAIL overflow_%0d: ok=%b bcd=%h ovf=%b, required bcd=%h ovf=%b", vin[i], ok, bcd, overflow, vexp[i], vovf[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        bad = 0;
        pulse_start(14'd500);          // accepted at edge k, now after k
        repeat (4) tick();             // after k+4
        pulse_start(14'd777);          // edge k+5, must be ignored
        tests_run++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_ignore: busy=%b done=%b, required 1 0", busy, done);
        end
        repeat (8) tick();             // after k+13
        bin   = 14'd777;
        start = 1'b1;
        tick();                        // edge k+14
        tests_run++;
        if (done !== 1'b1 || bcd !== 16'h0500 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_first: done=%b bcd=%h ovf=%b, required 1 0500 0", done, bcd, overflow);
        end
        tick();                        // edge k+15, start accepted during done
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_accept: busy=%b, required 1", busy);
        end
        for (int i = 0; i < 14; i++) begin
            if (bcd !== 16'h0500 || done !== 1'b0) bad++;
            tick();
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL b2b_hold: %0d cycles with bcd changed or early done, required 0", bad);
        end
        tests_run++;
        if (done !== 1'b1 || bcd !== 16'h0777) begin
            tests_failed++;
            $display("FAIL b2b_second: done=%b bcd=%h, required 1 0777", done, bcd);
        end
        tick();
    endtask

    task automatic test_reset_midconv();
        bit ok;
        pulse_start(14'd1234);
        wait_done(ok);
        tests_run++;
        if (!ok || bcd !== 16'h1234) begin
            tests_failed++;
            $display("FAIL pre_reset: ok=%b bcd=%h, required 1234", ok, bcd);
        end
        tick();
        pulse_start(14'd8888);         // edge k
        repeat (6) tick();             // after k+6
        @(posedge clk);                // edge k+7
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (bcd !== 16'h0000 || busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: bcd=%h busy=%b done=%b ovf=%b, required 0000 0 0 0", bcd, busy, done, overflow);
        end
        tick();
        rst = 1'b0;
        tick();
        pulse_start(14'd8888);
        wait_done(ok);
        tests_run++;
        if (!ok || bcd !== 16'h8888 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset: ok=%b bcd=%h ovf=%b, required 8888 0", ok, bcd, overflow);
        end
        tick();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        test_reset();
        test_latency();
        test_boundaries();
        test_overflow();
        test_back_to_back();
        test_reset_midconv();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bin_a_bcd.md
Name: bin_a_bcd

Overview:
- Sequential binary-to-BCD converter using the shift-add-3 (double-dabble) method.
- Converts a 14-bit unsigned value to four packed BCD digits.
- Sits directly upstream of the 4-digit multiplexed 7-segment driver; its bcd output feeds the driver's 16-bit digit input, so values show in decimal instead of hex.
- One conversion per start request; the last result is held stable between conversions so the display never flickers.

Parameters:
- BIN_W, 14, width of the binary input; one shift cycle per bit.
- MAX_VAL, 9999, largest representable value; inputs above it saturate.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  conversion request; sampled only in IDLE.
- bin  input  BIN_W  unsigned binary value; captured on the accepted start edge.
- bcd  output  16  packed BCD result: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units; held until the next completion.
- busy  output  1  high while a conversion is in progress.
- done  output  1  single-cycle pulse when bcd is updated.
- overflow  output  1  set if the last converted input exceeded MAX_VAL; updated together with bcd.

Behaviour:
- Clock and reset: one clock domain (clk); reset is asynchronous and active-high (rst).
- Reset values: bcd=16'h0000, busy=0, done=0, overflow=0, state=IDLE, iteration counter=0, shift register=0.
  - Reset is asserted asynchronously and takes effect immediately, including mid-conversion; the in-flight result is discarded.
- FSM states: IDLE, SHIFT.
- IDLE:
  - If start=1 at edge k:
    - Capture bin into the binary shift field.
    - If bin>MAX_VAL, load MAX_VAL instead and set an internal ovf flag; otherwise ovf=0.
    - Clear the 16-bit BCD working field and set counter=0.
    - Go to SHIFT; busy=1 after edge k.
  - If start=0, stay in IDLE.
- SHIFT (one iteration per edge):
  - Each BCD working nibble >=5 gets +3 (all four nibbles corrected in parallel, combinationally).
  - Then the concatenated {bcd_work, bin_work} register shifts left by 1 and counter increments.
- Completion, on the edge performing iteration BIN_W (edge k+BIN_W):
  - bcd <= corrected-and-shifted BCD field.
  - overflow <= ovf.
  - done <= 1 for exactly one cycle; busy <= 0; state <= IDLE.
- Latency: result valid and done high in the cycle after edge k+BIN_W, i.e. 14 clocks after the start edge. Throughput is one conversion per BIN_W+1 cycles.
- start while busy=1: ignored, not queued.
- start high in the same cycle done is high: accepted (FSM is in IDLE); bcd keeps the just-completed value until the new conversion finishes.
- bin changes after the accepted start: no effect on the current conversion.
- start held high continuously: back-to-back conversions, done every 15 cycles.
- bcd and overflow are registered and never change except at completion or reset. No glitches reach the display.
- Counter width is ceil(log2(BIN_W+1)) bits. Counter and nibble arithmetic never wrap, because the input is saturated to MAX_VAL so no BCD digit exceeds 9.

Test Plan:
- Reset, then idle 20 cycles -> bcd=16'h0000, busy=0, done never asserted, overflow=0.
- bin=1234, start pulse at edge k -> busy=1 for cycles k+1..k+14; done=1 only after edge k+14; bcd=16'h1234, overflow=0.
- Boundary values converted sequentially: bin=0 -> 16'h0000; bin=9 -> 16'h0009; bin=10 -> 16'h0010; bin=9999 -> 16'h9999. All have overflow=0.
- bin=12000 (and bin=16383) -> bcd=16'h9999, overflow=1. A following conversion of bin=42 -> bcd=16'h0042, overflow=0.
- Start bin=500, then pulse start with bin=777 at edge k+5 -> second request ignored; bcd=16'h0500 at k+14. Start held high across done -> next result 16'h0777 after 14 more edges, with bcd=16'h0500 stable in between.
- Complete a conversion to 16'h1234, start bin=8888, assert rst at edge k+7 -> immediately bcd=16'h0000, busy=0, done=0. After release, bin=8888 with start -> bcd=16'h8888.
